// File: rtl/fc_apb_pkg.sv
// fc_apb_pkg
// Shared definitions for the FC accelerator APB initiator:
//   - apb_state_e          : initiator state encoding (IDLE, SETUP, ACCESS, RESP)
//   - FC_APB_TIMEOUT_DEFAULT : default ACCESS wait limit used when the timeout
//                            feature (macro FC_APB_TIMEOUT_EN) is compiled in
//   - FC_REG_*             : byte offsets of the FC block's APB registers
package fc_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam int unsigned FC_APB_TIMEOUT_DEFAULT = 255;

    localparam logic [31:0] FC_REG_COMMAND     = 32'h0000_0000;
    localparam logic [31:0] FC_REG_SIZE        = 32'h0000_0004;
    localparam logic [31:0] FC_REG_START       = 32'h0000_0008;
    localparam logic [31:0] FC_REG_DONE        = 32'h0000_000C;
    localparam logic [31:0] FC_REG_CLK_COUNTER = 32'h0000_0010;
    localparam logic [31:0] FC_REG_MAX_INDEX   = 32'h0000_0014;

endpackage

// File: rtl/fc_apb_wait_timer.sv
// fc_apb_wait_timer
// Counts ACCESS wait cycles for the APB initiator's optional timeout.
// Only instantiated when FC_APB_TIMEOUT_EN is defined.
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous active-high reset
//   clear_i   : zero the count (asserted the cycle before ACCESS begins)
//   enable_i  : count this cycle (ACCESS with PREADY low)
//   expired_o : count has reached LIMIT
module fc_apb_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LimitVal = W'(LIMIT);

    logic [W-1:0] count_q;

    // Wait counter: cleared on the way into ACCESS, then advances once per
    // stalled ACCESS cycle. It stops at LIMIT so it can never wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != LimitVal)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == LimitVal);

endmodule

// File: rtl/fc_apb_initiator.sv
// fc_apb_initiator
// APB bridge master for the FC accelerator register slave. Accepts one
// request on a valid/ready channel, runs one SETUP/ACCESS transfer and
// returns read data plus error status on a one-entry response channel.
// Ports:
//   CLK, RESET                          : clock, async active-high reset
//   REQ_VALID/READY/WRITE/ADDR/WDATA    : request channel
//   RSP_VALID/READY/RDATA/ERR           : response channel
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA    : APB master outputs
//   PRDATA/PREADY/PSLVERR               : APB slave returns
//   BUSY                                : high whenever not IDLE
// Optional feature: define FC_APB_TIMEOUT_EN to abort ACCESS phases that
// stall longer than TIMEOUT_CYCLES.
module fc_apb_initiator
    import fc_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = FC_APB_TIMEOUT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY
);

    apb_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rspRdata_q;
    logic                  rspErr_q;

    logic accept;
    logic complete;
    logic abort;

    assign accept   = (state_q == IDLE) && REQ_VALID;
    assign complete = (state_q == ACCESS) && PREADY;

`ifdef FC_APB_TIMEOUT_EN
    logic timerExpired;

    fc_apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clear_i  (state_q == SETUP),
        .enable_i ((state_q == ACCESS) && !PREADY),
        .expired_o(timerExpired)
    );

    // A ready slave in the expiry cycle still wins: only abort when PREADY is low.
    assign abort = (state_q == ACCESS) && !PREADY && timerExpired;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign abort          = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SETUP always lasts one cycle; ACCESS waits on PREADY
    // (or the timeout); RESP holds until the response is consumed.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (REQ_VALID)           state_d = SETUP;
            SETUP:                            state_d = ACCESS;
            ACCESS:  if (complete || abort)   state_d = RESP;
            RESP:    if (RSP_READY)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // Output decode straight from the state register, so PSEL/PENABLE drop
    // the moment RESET forces IDLE.
    always_comb begin
        REQ_READY = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        RSP_VALID = 1'b0;
        BUSY      = 1'b1;
        unique case (state_q)
            IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
            end
            SETUP: begin
                PSEL = 1'b1;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            RESP: begin
                RSP_VALID = 1'b1;
            end
            default: begin
                BUSY = 1'b1;
            end
        endcase
    end

    // Transfer attributes are captured on the request handshake and left
    // alone afterwards, which keeps them stable through SETUP and ACCESS.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (accept) begin
            paddr_q  <= REQ_ADDR;
            pwrite_q <= REQ_WRITE;
            pwdata_q <= REQ_WDATA;
        end
    end

    // Response capture. PSLVERR is only looked at alongside PREADY; writes
    // and aborted transfers return zero data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else if (complete) begin
            rspRdata_q <= pwrite_q ? '0 : PRDATA;
            rspErr_q   <= PSLVERR;
        end else if (abort) begin
            rspRdata_q <= '0;
            rspErr_q   <= 1'b1;
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign RSP_RDATA = rspRdata_q;
    assign RSP_ERR   = rspErr_q;

endmodule

// File: tb/tb_fc_apb_initiator.sv
// tb_fc_apb_initiator
// Directed bench for fc_apb_initiator. The APB slave is modelled by
// driving PREADY/PRDATA/PSLVERR directly from the stimulus sequence.
// With FC_APB_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4
// and the stuck-slave abort case is exercised too.
module tb_fc_apb_initiator;
    import fc_apb_pkg::*;

`ifdef FC_APB_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = FC_APB_TIMEOUT_DEFAULT;
`endif

    logic        CLK;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        BUSY;

    int checks;
    int failures;

    fc_apb_initiator #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TbTimeout)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR (REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR  (RSP_ERR),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .BUSY     (BUSY)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a request; it is taken on the next rising edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
    endtask

    // Stimulus sequence: reset, then the directed scenarios one after another.
    initial begin
        checks    = 0;
        failures  = 0;
        RESET     = 1'b1;
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        RSP_READY = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_req_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("rst_psel",      {31'b0, PSEL},      32'd0);
        checkOutput("rst_penable",   {31'b0, PENABLE},   32'd0);
        checkOutput("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        checkOutput("rst_busy",      {31'b0, BUSY},      32'd0);
        checkOutput("rst_paddr",     PADDR,              32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // Write 0x5 to COMMAND, slave ready immediately
        PRDATA = 32'h0000_1234;
        applyStimulus(1'b1, FC_REG_COMMAND, 32'h5);
        checkOutput("wr_req_ready_idle", {31'b0, REQ_READY}, 32'd1);
        tick();
        REQ_VALID = 1'b0;
        checkOutput("wr_setup_psel",    {31'b0, PSEL},     32'd1);
        checkOutput("wr_setup_penable", {31'b0, PENABLE},  32'd0);
        checkOutput("wr_setup_req_rdy", {31'b0, REQ_READY},32'd0);
        checkOutput("wr_pwdata",        PWDATA,            32'h5);
        checkOutput("wr_pwrite",        {31'b0, PWRITE},   32'd1);
        checkOutput("wr_paddr",         PADDR,             FC_REG_COMMAND);
        tick();
        checkOutput("wr_access_psel",    {31'b0, PSEL},    32'd1);
        checkOutput("wr_access_penable", {31'b0, PENABLE}, 32'd1);
        tick();
        checkOutput("wr_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
        checkOutput("wr_rsp_rdata", RSP_RDATA,          32'd0);
        checkOutput("wr_rsp_err",   {31'b0, RSP_ERR},   32'd0);
        checkOutput("wr_rsp_psel",  {31'b0, PSEL},      32'd0);
        tick();
        checkOutput("wr_back_idle", {31'b0, BUSY}, 32'd0);

        // Read CLK_COUNTER with three wait states; PSLVERR noise while not ready
        applyStimulus(1'b0, FC_REG_CLK_COUNTER, 32'hFFFF_FFFF);
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        REQ_ADDR  = 32'hAAAA_AAAA;
        tick();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("rd_wait%0d_penable", i), {31'b0, PENABLE}, 32'd1);
            checkOutput($sformatf("rd_wait%0d_paddr", i),   PADDR, FC_REG_CLK_COUNTER);
            tick();
        end
        checkOutput("rd_access4_penable", {31'b0, PENABLE}, 32'd1);
        checkOutput("rd_access4_paddr",   PADDR,             FC_REG_CLK_COUNTER);
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0000_0007;
        tick();
        checkOutput("rd_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
        checkOutput("rd_rsp_rdata", RSP_RDATA,          32'h7);
        checkOutput("rd_rsp_err",   {31'b0, RSP_ERR},   32'd0);
        checkOutput("rd_paddr_kept", PADDR,             FC_REG_CLK_COUNTER);
        tick();

        // Read DONE with slave error, response stalled 10 cycles while a
        // new request (write START) waits
        RSP_READY = 1'b0;
        PSLVERR   = 1'b1;
        PRDATA    = 32'hDEAD_BEEF;
        applyStimulus(1'b0, FC_REG_DONE, 32'h0);
        tick();
        applyStimulus(1'b1, FC_REG_START, 32'h1);
        tick();
        tick();
        PSLVERR = 1'b0;
        checkOutput("err_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
        checkOutput("err_rsp_err",   {31'b0, RSP_ERR},   32'd1);
        checkOutput("err_rsp_rdata", RSP_RDATA,          32'hDEAD_BEEF);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_req_ready", i), {31'b0, REQ_READY}, 32'd0);
            checkOutput($sformatf("stall%0d_psel", i),      {31'b0, PSEL},      32'd0);
            checkOutput($sformatf("stall%0d_rsp_err", i),   {31'b0, RSP_ERR},   32'd1);
        end
        checkOutput("stall_rdata_held", RSP_RDATA, 32'hDEAD_BEEF);
        RSP_READY = 1'b1;
        tick();
        checkOutput("after_rsp_req_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("after_rsp_psel",      {31'b0, PSEL},      32'd0);
        tick();
        REQ_VALID = 1'b0;
        checkOutput("next_setup_psel", {31'b0, PSEL}, 32'd1);
        checkOutput("next_paddr",      PADDR,         FC_REG_START);
        tick();
        tick();
        checkOutput("next_rsp_rdata", RSP_RDATA,        32'd0);
        checkOutput("next_rsp_err",   {31'b0, RSP_ERR}, 32'd0);
        tick();

`ifdef FC_APB_TIMEOUT_EN
        // Stuck slave: ACCESS cycles with count 0..3 stall, count 4 aborts
        PREADY = 1'b0;
        PRDATA = 32'h0000_0055;
        applyStimulus(1'b0, FC_REG_MAX_INDEX, 32'h0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("to_wait%0d_penable", i), {31'b0, PENABLE}, 32'd1);
        end
        tick();
        checkOutput("to_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
        checkOutput("to_rsp_err",   {31'b0, RSP_ERR},   32'd1);
        checkOutput("to_rsp_rdata", RSP_RDATA,          32'd0);
        checkOutput("to_psel",      {31'b0, PSEL},      32'd0);
        tick();
        PREADY = 1'b1;
`endif

        // Reset in the middle of ACCESS
        PREADY = 1'b0;
        applyStimulus(1'b0, FC_REG_SIZE, 32'h0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        checkOutput("mid_access_penable", {31'b0, PENABLE}, 32'd1);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("rst_mid_psel",      {31'b0, PSEL},      32'd0);
        checkOutput("rst_mid_penable",   {31'b0, PENABLE},   32'd0);
        checkOutput("rst_mid_busy",      {31'b0, BUSY},      32'd0);
        checkOutput("rst_mid_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
        @(negedge CLK);
        RESET  = 1'b0;
        PREADY = 1'b1;
        tick();
        checkOutput("rst_release_req_ready", {31'b0, REQ_READY}, 32'd1);
        checkOutput("rst_release_rdata",     RSP_RDATA,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout, expected sequence end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
